// File: rtl/act_skew_feeder_pkg.sv
// Shared types and constants for the activation skew feeder and PE array.
// Holds the feeder FSM state type and the default array geometry.
package act_skew_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam int ACT_DW  = 8;
    localparam int PE_ROWS = 4;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth data+valid delay chain; data is forced to zero when invalid.
// Ports: CLK, RSTN, CLR, IN_VALID/IN_DATA in, OUT_VALID/OUT_DATA after DEPTH cycles.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          CLR,
    input  logic          IN_VALID,
    input  logic [DW-1:0] IN_DATA,
    output logic          OUT_VALID,
    output logic [DW-1:0] OUT_DATA
);

    logic          v_q [DEPTH];
    logic [DW-1:0] d_q [DEPTH];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                v_q[i] <= 1'b0;
                d_q[i] <= '0;
            end
        end else if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                v_q[i] <= 1'b0;
                d_q[i] <= '0;
            end
        end else begin
            v_q[0] <= IN_VALID;
            d_q[0] <= IN_VALID ? IN_DATA : '0;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign OUT_VALID = v_q[DEPTH-1];
    assign OUT_DATA  = d_q[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Feeds K_LEN activation vectors into PE column 0 with a 1+r cycle row skew.
// Ports: CLK, RSTN, CLR, START/K_LEN, IN_VALID/IN_READY/IN_DATA,
//        A_OUT/EN_OUT to the array, BUSY and DONE status.
module act_skew_feeder
    import act_skew_feeder_pkg::*;
#(
    parameter int ROWS = PE_ROWS,
    parameter int DW   = ACT_DW,
    parameter int KW   = 8
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               CLR,
    input  logic               START,
    input  logic [KW-1:0]      K_LEN,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [ROWS*DW-1:0] IN_DATA,
    output logic [ROWS*DW-1:0] A_OUT,
    output logic [ROWS-1:0]    EN_OUT,
    output logic               BUSY,
    output logic               DONE
);

    state_t        state_q, state_d;
    logic [KW-1:0] cnt_q, cnt_d;
    logic          zdone_q, zdone_d;
    logic          accept;
    logic          last_in;
    logic          last_out;
    logic          done_last;

    assign IN_READY  = (state_q == STREAM);
    assign BUSY      = (state_q != IDLE);
    assign accept    = IN_VALID & IN_READY;
    assign last_in   = accept & (cnt_q == KW'(1));
    // LAST rides with the final row, so its arrival marks full delivery.
    assign done_last = (state_q == DRAIN) & EN_OUT[ROWS-1] & last_out;
    assign DONE      = zdone_q | done_last;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zdone_q <= zdone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zdone_d = 1'b0;
        if (CLR) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (START) begin
                        if (K_LEN != '0) begin
                            state_d = STREAM;
                            cnt_d   = K_LEN;
                        end else begin
                            zdone_d = 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        cnt_d = cnt_q - KW'(1);
                        if (cnt_q == KW'(1)) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (done_last) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DW-1:0] d_in;
        assign d_in = IN_DATA[r*DW +: DW];

        if (r == ROWS - 1) begin : g_tag
            logic [DW:0] q;
            logic        v;
            skew_delay_line #(
                .DEPTH(r + 1),
                .DW   (DW + 1)
            ) u_dl (
                .CLK      (CLK),
                .RSTN     (RSTN),
                .CLR      (CLR),
                .IN_VALID (accept),
                .IN_DATA  ({last_in, d_in}),
                .OUT_VALID(v),
                .OUT_DATA (q)
            );
            assign EN_OUT[r]          = v;
            assign A_OUT[r*DW +: DW]  = q[DW-1:0];
            assign last_out           = q[DW];
        end else begin : g_plain
            logic [DW-1:0] q;
            logic          v;
            skew_delay_line #(
                .DEPTH(r + 1),
                .DW   (DW)
            ) u_dl (
                .CLK      (CLK),
                .RSTN     (RSTN),
                .CLR      (CLR),
                .IN_VALID (accept),
                .IN_DATA  (d_in),
                .OUT_VALID(v),
                .OUT_DATA (q)
            );
            assign EN_OUT[r]         = v;
            assign A_OUT[r*DW +: DW] = q;
        end
    end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder (ROWS=4, DW=8): per-cycle vector table
// plus hand-written clear and asynchronous reset sequences.
module tb_act_skew_feeder;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        CLR;
    logic        START;
    logic [7:0]  K_LEN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_DATA;
    logic [31:0] A_OUT;
    logic [3:0]  EN_OUT;
    logic        BUSY;
    logic        DONE;

    int total = 0;
    int bad   = 0;

    act_skew_feeder #(.ROWS(4), .DW(8), .KW(8)) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .CLR     (CLR),
        .START   (START),
        .K_LEN   (K_LEN),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .IN_DATA (IN_DATA),
        .A_OUT   (A_OUT),
        .EN_OUT  (EN_OUT),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        s;
        logic [7:0]  k;
        logic        v;
        logic [31:0] d;
        logic [3:0]  en;
        logic [31:0] a;
        logic        dn;
        logic        b;
        logic        r;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic [7:0] k, logic v,
                                logic [31:0] d, logic [3:0] en,
                                logic [31:0] a, logic dn, logic b,
                                logic r);
        vec_t t;
        t.s = s; t.k = k; t.v = v; t.d = d;
        t.en = en; t.a = a; t.dn = dn; t.b = b; t.r = r;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_all(string nm, logic [3:0] en, logic [31:0] a,
                           logic dn, logic b, logic r);
        chk({nm, ".en"}, {28'd0, EN_OUT}, {28'd0, en});
        chk({nm, ".a"}, A_OUT, a);
        chk({nm, ".done"}, {31'd0, DONE}, {31'd0, dn});
        chk({nm, ".busy"}, {31'd0, BUSY}, {31'd0, b});
        chk({nm, ".ready"}, {31'd0, IN_READY}, {31'd0, r});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    localparam logic [31:0] V1 = 32'h04030201;
    localparam logic [31:0] V2 = 32'h08070605;
    localparam logic [31:0] V3 = 32'hFCFDFEFF;
    localparam logic [31:0] W1 = 32'h281E140A;
    localparam logic [31:0] W2 = 32'h291F150B;
    localparam logic [31:0] JK = 32'h55555555;

    initial begin
        RSTN = 1'b0; CLR = 1'b0; START = 1'b0; K_LEN = '0;
        IN_VALID = 1'b0; IN_DATA = '0;

        // basic burst, IN_VALID held high
        tbl.push_back(mk(1, 3, 0, 0,  4'h0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 1, V1, 4'h0, 32'h0,        0, 1, 1));
        tbl.push_back(mk(0, 0, 1, V2, 4'h1, 32'h00000001, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, V3, 4'h3, 32'h00000205, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, JK, 4'h7, 32'h000306FF, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, JK, 4'hE, 32'h0407FE00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, JK, 4'hC, 32'h08FD0000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, JK, 4'h8, 32'hFC000000, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4'h0, 32'h0,        0, 0, 0));
        // one-cycle bubble after the first vector
        tbl.push_back(mk(1, 3, 0, 0,  4'h0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 1, V1, 4'h0, 32'h0,        0, 1, 1));
        tbl.push_back(mk(0, 0, 0, V2, 4'h1, 32'h00000001, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, V2, 4'h2, 32'h00000200, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, V3, 4'h5, 32'h00030005, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,  4'hB, 32'h040006FF, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4'h6, 32'h0007FE00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4'hC, 32'h08FD0000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4'h8, 32'hFC000000, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4'h0, 32'h0,        0, 0, 0));
        // zero-length burst
        tbl.push_back(mk(1, 0, 0, 0,  4'h0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4'h0, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4'h0, 32'h0,        0, 0, 0));
        // START outside IDLE ignored, then back-to-back burst
        tbl.push_back(mk(1, 2, 0, 0,  4'h0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 7, 1, W1, 4'h0, 32'h0,        0, 1, 1));
        tbl.push_back(mk(1, 1, 1, W2, 4'h1, 32'h0000000A, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,  4'h3, 32'h0000140B, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4'h6, 32'h001E1500, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4'hC, 32'h281F0000, 0, 1, 0));
        tbl.push_back(mk(1, 3, 0, 0,  4'h8, 32'h29000000, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0,  4'h0, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0201807F,
                                      4'h0, 32'h0,        0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 32'h11111111,
                                      4'h1, 32'h0000007F, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4'h2, 32'h00008000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4'h4, 32'h00010000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4'h8, 32'h02000000, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4'h0, 32'h0,        0, 0, 0));

        #3;
        chk_all("reset", 4'h0, 32'h0, 0, 0, 0);
        #14 RSTN = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            START    = tbl[i].s;
            K_LEN    = tbl[i].k;
            IN_VALID = tbl[i].v;
            IN_DATA  = tbl[i].d;
            @(negedge CLK);
            chk_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].a,
                    tbl[i].dn, tbl[i].b, tbl[i].r);
            tick();
        end

        // CLR two cycles after the first accept of a 5-vector burst
        START = 1'b1; K_LEN = 8'd5; IN_VALID = 1'b0;
        tick();
        START = 1'b0; IN_VALID = 1'b1; IN_DATA = V1;
        tick();
        IN_DATA = V2;
        tick();
        CLR = 1'b1; IN_DATA = V3;
        tick();
        CLR = 1'b0; IN_VALID = 1'b0;
        @(negedge CLK);
        chk_all("clr", 4'h0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge CLK);
            chk($sformatf("clr_quiet%0d", i), {27'd0, DONE, EN_OUT},
                32'd0);
        end
        tick();
        START = 1'b1; K_LEN = 8'd1;
        tick();
        START = 1'b0; IN_VALID = 1'b1; IN_DATA = 32'h33221100;
        @(negedge CLK);
        chk_all("clr_new_acc", 4'h0, 32'h0, 0, 1, 1);
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        tick();
        @(negedge CLK);
        chk_all("clr_new_done", 4'h8, 32'h33000000, 1, 1, 0);
        tick();
        @(negedge CLK);
        chk_all("clr_new_idle", 4'h0, 32'h0, 0, 0, 0);

        // asynchronous reset mid-stream
        tick();
        START = 1'b1; K_LEN = 8'd3;
        tick();
        START = 1'b0; IN_VALID = 1'b1; IN_DATA = V1;
        tick();
        IN_DATA = V2;
        tick();
        #2;
        RSTN = 1'b0; START = 1'b1; K_LEN = 8'd1;
        #1;
        chk_all("arst", 4'h0, 32'h0, 0, 0, 0);
        tick();
        chk_all("arst_hold", 4'h0, 32'h0, 0, 0, 0);
        #3 RSTN = 1'b1;
        IN_VALID = 1'b0;
        tick();
        START = 1'b0; IN_VALID = 1'b1; IN_DATA = 32'h80000000;
        @(negedge CLK);
        chk_all("arst_start", 4'h0, 32'h0, 0, 1, 1);
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        tick();
        @(negedge CLK);
        chk_all("arst_done", 4'h8, 32'h80000000, 1, 1, 0);
        tick();
        @(negedge CLK);
        chk_all("arst_idle", 4'h0, 32'h0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 Parameter ROWS, default 4, number of PE-array rows fed (legal range 1..16).
REQ-002 Parameter DW, default 8, signed activation width matching PE A_IN.
REQ-003 Parameter KW, default 8, width of the vector-count field K_LEN.
REQ-004 CLK  input  1  clock; all state changes on rising edge.
REQ-005 RSTN  input  1  reset, asynchronous, active-low.
REQ-006 CLR  input  1  synchronous flush of all state and pipelines.
REQ-007 START  input  1  one-cycle request to begin a K_LEN-vector burst.
REQ-008 K_LEN  input  KW  number of activation vectors in the burst, sampled with START.
REQ-009 IN_VALID  input  1  IN_DATA holds a valid vector.
REQ-010 IN_READY  output  1  block accepts a vector this cycle.
REQ-011 IN_DATA  input  ROWS*DW  one activation per row; row r in bits [r*DW +: DW].
REQ-012 A_OUT  output  ROWS*DW  skewed activations to PE column 0 A_IN, row r slice as above.
REQ-013 EN_OUT  output  ROWS  per-row enable to PE column 0 ENLeft.
REQ-014 BUSY  output  1  burst in progress.
REQ-015 DONE  output  1  one-cycle pulse, burst fully delivered.

Function
REQ-016 FSM states IDLE, STREAM, DRAIN; IDLE after reset or CLR.
REQ-017 IDLE: START with K_LEN!=0 -> STREAM, vector counter loaded with K_LEN; START with K_LEN==0 -> DONE pulses next cycle, stay IDLE.
REQ-018 START outside IDLE ignored; K_LEN changes outside the START cycle ignored.
REQ-019 IN_READY = (state==STREAM), decoded from state only, never from IN_VALID.
REQ-020 Accept = IN_VALID & IN_READY; each accept decrements counter; accept at count 1 tags vector LAST, next state DRAIN.
REQ-021 STREAM cycle without accept inserts a bubble: EN_OUT low on every row at its skewed slot; counter unchanged.
REQ-022 Row r latency from accept edge = 1 + r cycles: A_OUT[r] and EN_OUT[r] carry accepted row-r data exactly r+1 cycles after the accept cycle.
REQ-023 A_OUT row slice SHALL be 0 whenever its EN_OUT bit is 0.
REQ-024 Data passed unmodified (no arithmetic, no sign change), signed DW bits.
REQ-025 LAST tag travels with row ROWS-1; DONE asserts in the same cycle EN_OUT[ROWS-1] carries the LAST vector; state -> IDLE on that edge.
REQ-026 ROWS==1: DONE coincides with EN_OUT[0] of the LAST vector; DRAIN lasts 1 cycle.
REQ-027 BUSY high from the cycle after START (K_LEN!=0) through the DONE cycle inclusive; low otherwise.
REQ-028 CLR mid-burst: next cycle all EN_OUT, A_OUT, DONE, BUSY, IN_READY 0, state IDLE, no DONE for the aborted burst; CLR has priority over START.
REQ-029 Back-to-back: START accepted in the DONE cycle's following IDLE cycle; no overlap of bursts.

Reset
REQ-030 RSTN low forces asynchronously: state IDLE, counter 0, all delay stages 0, A_OUT 0, EN_OUT 0, IN_READY 0, BUSY 0, DONE 0.
REQ-031 After RSTN deasserts, first START honoured on the first rising edge.

Structure
REQ-032 Shared package holds FSM state type (IDLE/STREAM/DRAIN) and default DW/ROWS constants used by the PE array.
REQ-033 One sub-module skew_delay_line (parameters DEPTH, DW; data+valid chain, zero on invalid) instantiated per row with DEPTH=r+1; row ROWS-1 instance also carries the LAST bit.
REQ-034 No combinational path from IN_VALID or IN_DATA to any output.

Verification (ROWS=4, DW=8)
REQ-035 START K_LEN=3, IN_VALID held high, vectors {1,2,3,4},{5,6,7,8},{-1,-2,-3,-4} -> row0 EN at T+2..T+4 with 1,5,-1; row3 EN at T+5..T+7 with 4,8,-4; DONE at T+7.
REQ-036 K_LEN=3 with IN_VALID low one cycle after first vector -> EN gap of one cycle on every row at its skewed slot; DONE one cycle later than REQ-035.
REQ-037 START K_LEN=0 -> DONE one cycle later, BUSY and EN_OUT stay 0.
REQ-038 CLR asserted two cycles after first accept of K_LEN=5 -> next cycle all outputs 0, no DONE; new START K_LEN=1 completes normally.
REQ-039 RSTN pulsed low mid-STREAM, asynchronous to CLK -> outputs 0 immediately; START ignored while RSTN low.
REQ-040 START asserted during STREAM with different K_LEN -> ignored; burst length and DONE timing unchanged.
